conv_rgb2ycc: RTL and testbench

//  Streaming RGB -> Y / YCbCr converter with an output FWFT FIFO.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/sync_fifo_fwft.sv | 74 +++++++
 rtl/conv_rgb2ycc.sv | 134 +++++++++++++
 tb/tb_conv_rgb2ycc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the RGB -> Y/YCbCr converter: Q8 coefficients,
// chroma offset helper, pipeline depth and output mode encoding.
package conv_pkg;

  typedef enum logic {
    MODE_Y   = 1'b0,
    MODE_YCC = 1'b1
  } mode_e;

  localparam int PIPE_LAT   = 3;
  localparam int Q_SHIFT    = 8;
  localparam int ROUND_HALF = 1 << (Q_SHIFT - 1);

  // Row = output (Y, Cb, Cr), column = input component (R, G, B).
  function automatic int coef(input int row, input int col);
    int c;
    c = 0;
    case (row)
      0: c = (col == 0) ?  77 : (col == 1) ?  150 :  29;
      1: c = (col == 0) ? -43 : (col == 1) ?  -85 : 128;
      default: c = (col == 0) ? 128 : (col == 1) ? -107 : -21;
    endcase
    return c;
  endfunction

  function automatic int cb_cr_offset(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: array storage with a registered
// output word; level counts the output register plus stored words.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] dout_reg;

  logic push;
  logic pop;
  logic load;

  assign full  = (level_reg >= (AW+1)'(DEPTH));
  assign empty = !out_valid_reg;
  assign level = level_reg;
  assign dout  = dout_reg;

  assign push = wr_en && !full;
  assign pop  = rd_en && out_valid_reg;
  // Refill the output register when it is free or being consumed this cycle.
  assign load = (wr_ptr_reg != rd_ptr_reg) && (!out_valid_reg || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
    if (load) begin
      dout_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/conv_rgb2ycc.sv
// Streaming RGB -> Y / YCbCr converter, 3-stage free-running pipeline into a
// FWFT FIFO with credit flow control. Define CONV_RGB2YCC_ROUND_EN for rounding.
module conv_rgb2ycc
  import conv_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int COEF_W     = 9
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [3*DATA_W-1:0]           din,
  input  logic                          mode,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [3*DATA_W-1:0]           dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ovf
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + 2;

  logic [2:0][DATA_W-1:0]     comp;
  logic signed [PROD_W-1:0]   prod_reg [3][3];
  logic signed [SUM_W-1:0]    sum_reg  [3];
  logic [2:0][DATA_W-1:0]     res_next;
  logic [2:0][DATA_W-1:0]     res_reg;
  logic                       v1_reg, v2_reg, v3_reg;
  mode_e                      m1_reg, m2_reg, m3_reg;
  logic                       ovf_reg;
  logic                       accept;
  logic [3*DATA_W-1:0]        fifo_din;
  logic [CNT_W-1:0]           fifo_level;
  logic                       fifo_full_unused;

  // comp[0]=R, comp[1]=G, comp[2]=B; R sits in the MSBs of din.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comp
      assign comp[gi] = din[(3-gi)*DATA_W-1 -: DATA_W];
    end
  endgenerate

  // Credits come only from registered state, so a read frees space next cycle.
  assign count  = fifo_level + CNT_W'(v1_reg) + CNT_W'(v2_reg) + CNT_W'(v3_reg);
  assign full   = (count >= CNT_W'(FIFO_DEPTH));
  assign accept = wr_en && !full;
  assign ovf    = ovf_reg;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_reg[i][j] <= PROD_W'($signed({1'b0, comp[j]})) *
                          PROD_W'(COEF_W'(coef(i, j)));
      end
      if (i != 0 && m1_reg == MODE_Y) begin
        sum_reg[i] <= '0;
      end else begin
        sum_reg[i] <= SUM_W'(prod_reg[i][0]) + SUM_W'(prod_reg[i][1]) +
                      SUM_W'(prod_reg[i][2]);
      end
    end
    res_reg <= res_next;
    m1_reg  <= mode_e'(mode);
    m2_reg  <= m1_reg;
    m3_reg  <= m2_reg;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      v3_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      v1_reg <= accept;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
      if (wr_en && full) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_post
      localparam int OFFSET_I = (gi == 0) ? 0 : cb_cr_offset(DATA_W);
      localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << DATA_W) - 1);
      logic signed [SUM_W-1:0] biased;
      logic signed [SUM_W-1:0] shifted;
      logic [DATA_W-1:0]       res_ch;

      always_comb begin
`ifdef CONV_RGB2YCC_ROUND_EN
        biased = sum_reg[gi] + SUM_W'(ROUND_HALF);
`else
        biased = sum_reg[gi];
`endif
        shifted = (biased >>> Q_SHIFT) + SUM_W'(OFFSET_I);
        res_ch  = shifted[DATA_W-1:0];
        if (shifted < 0) begin
          res_ch = '0;
        end else if (shifted > SAT_MAX) begin
          res_ch = '1;
        end
      end

      assign res_next[gi] = res_ch;
    end
  endgenerate

  assign fifo_din = (m3_reg == MODE_YCC) ? {res_reg[0], res_reg[1], res_reg[2]}
                                         : {{(2*DATA_W){1'b0}}, res_reg[0]};

  sync_fifo_fwft #(
    .WIDTH (3*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (srst),
    .din   (fifo_din),
    .wr_en (v3_reg),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (fifo_full_unused),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_conv_rgb2ycc.sv
// Self-checking bench for conv_rgb2ycc: directed vector table, backpressure,
// mixed-mode stream against an integer model, and mid-stream reset.
module tb_conv_rgb2ycc;

  logic        clk = 1'b0;
  logic        srst;
  logic [23:0] din;
  logic        mode;
  logic        wr_en;
  logic        rd_en;
  logic [23:0] dout;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  conv_rgb2ycc dut (
    .clk   (clk),
    .srst  (srst),
    .din   (din),
    .mode  (mode),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf)
  );

  typedef struct {
    string       name;
    logic [23:0] din;
    logic        mode;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int fdiv256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic int sat8(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic logic [23:0] ref_pix(input logic [23:0] p, input logic m);
    int r, g, b, ys, cbs, crs, rnd;
    logic [7:0] y8, cb8, cr8;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
`ifdef CONV_RGB2YCC_ROUND_EN
    rnd = 128;
`else
    rnd = 0;
`endif
    ys  =  77 * r + 150 * g +  29 * b + rnd;
    cbs = -43 * r -  85 * g + 128 * b + rnd;
    crs = 128 * r - 107 * g -  21 * b + rnd;
    y8  = 8'(sat8(fdiv256(ys)));
    cb8 = 8'(sat8(fdiv256(cbs) + 128));
    cr8 = 8'(sat8(fdiv256(crs) + 128));
    return m ? {y8, cb8, cr8} : {16'h0000, y8};
  endfunction

  initial begin
    int cyc;
    int sent;
    int stale;
    logic [23:0] p;

    srst = 1'b1; din = '0; mode = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    vecs[0] = '{"m0_white", 24'hFFFFFF, 1'b0, 24'h0000FF};
    vecs[1] = '{"m1_black", 24'h000000, 1'b1, 24'h008080};
    vecs[2] = '{"m1_white", 24'hFFFFFF, 1'b1, 24'hFF8080};
    vecs[3] = '{"m1_green", 24'h00FF00, 1'b1, 24'h952B15};
`ifdef CONV_RGB2YCC_ROUND_EN
    vecs[4] = '{"m0_red",   24'hFF0000, 1'b0, 24'h00004D};
    vecs[5] = '{"m1_blue",  24'h0000FF, 1'b1, 24'h1DFF6B};
    vecs[6] = '{"m1_red",   24'hFF0000, 1'b1, 24'h4D55FF};
`else
    vecs[4] = '{"m0_red",   24'hFF0000, 1'b0, 24'h00004C};
    vecs[5] = '{"m1_blue",  24'h0000FF, 1'b1, 24'h1CFF6B};
    vecs[6] = '{"m1_red",   24'hFF0000, 1'b1, 24'h4C55FF};
`endif

    // Reset
    tick();
    srst = 1'b0;
    check("rst_full",  full,  0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_ovf",   ovf,   0);

    // Directed vectors with exact latency
    for (int i = 0; i < 7; i++) begin
      din = vecs[i].din; mode = vecs[i].mode; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      tick(); tick(); tick();
      check({vecs[i].name, "_early"}, empty, 1);
      tick();
      check({vecs[i].name, "_valid"}, empty, 0);
      check({vecs[i].name, "_dout"}, dout, vecs[i].exp);
      $display("vec %s din=%h mode=%0d dout=%h", vecs[i].name, vecs[i].din, vecs[i].mode, dout);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check({vecs[i].name, "_empty_after"}, empty, 1);
      check({vecs[i].name, "_count_after"}, count, 0);
    end
    check("ovf_clean", ovf, 0);

    // Backpressure: fill 16 credits without reading
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      p = {8'(i * 16), 8'(255 - i * 8), 8'(i * 3)};
      din = p; mode = 1'b1; wr_en = 1'b1;
      exp_q.push_back(ref_pix(p, 1'b1));
      tick();
    end
    check("bp_full", full, 1);
    check("bp_count16", count, 16);
    din = 24'hABCDEF;
    tick();
    check("bp_ovf", ovf, 1);
    check("bp_count_hold", count, 16);
    // Read on a full cycle: push still rejected, credit back next cycle
    din = 24'h123456; rd_en = 1'b1;
    check("bp_not_empty", empty, 0);
    check("bp_first", dout, exp_q.pop_front());
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("bp_credit_count", count, 15);
    check("bp_credit_full", full, 0);
    // Read and write together keep count
    p = 24'h40C020;
    din = p; wr_en = 1'b1; rd_en = 1'b1;
    check("rw_dout", dout, exp_q.pop_front());
    exp_q.push_back(ref_pix(p, 1'b1));
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_count", count, 15);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (!empty) begin
        rd_en = 1'b1;
        $display("drain dout=%h", dout);
        check("drain", dout, exp_q.pop_front());
      end else begin
        rd_en = 1'b0;
      end
      tick();
      cyc++;
    end
    rd_en = 1'b0;
    check("drain_timeout", cyc < 200, 1);
    tick();
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // Mode toggled every pixel, concurrent read
    sent = 0; cyc = 0;
    while ((sent < 32 || exp_q.size() > 0) && cyc < 400) begin
      if (sent < 32 && !full) begin
        p = 24'($urandom);
        din = p; mode = sent[0]; wr_en = 1'b1;
        exp_q.push_back(ref_pix(p, sent[0]));
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      if (!empty && exp_q.size() > 0) begin
        rd_en = 1'b1;
        $display("stream dout=%h", dout);
        check("stream", dout, exp_q.pop_front());
      end else begin
        rd_en = 1'b0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("stream_timeout", cyc < 400, 1);

    // Mid-stream reset with 5 stored and 3 in flight
    for (int i = 0; i < 8; i++) begin
      din = {8'(i), 8'(i * 7), 8'(200 - i)}; mode = 1'b1; wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    check("mid_count8", count, 8);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("mid_empty", empty, 1);
    check("mid_count", count, 0);
    check("mid_ovf", ovf, 0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!empty || count != 0) stale++;
    end
    check("mid_no_stale", stale, 0);
    p = 24'h0000FF;
    din = p; mode = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick(); tick(); tick(); tick();
    check("post_rst_valid", empty, 0);
    check("post_rst_dout", dout, ref_pix(p, 1'b1));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
